// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

   localparam int unsigned DEF_WIDTH = 5;
   localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Iteration counter width for an arbitrary operand width (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sub_ripple.sv
// Ripple-borrow subtractor built from full_adder cells: diff = a - b.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module sub_ripple #(
   parameter int unsigned N = 6
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N:0] c;

   // a + ~b + 1: two's-complement subtraction, carry-out low means a < b
   assign c[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
         .a   (a[i]),
         .b   (~b[i]),
         .cin (c[i]),
         .s   (diff[i]),
         .cout(c[i+1])
      );
   end

   assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider5.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
module seq_divider5
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned       CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;

   logic [WIDTH:0]   t;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH:0]   r_nx;
   logic [WIDTH-1:0] q_nx;
   logic             accept;
   logic             last;

   // R stays below D after every step, so its top bit is always 0 and the
   // truncating shift drops nothing.
   assign t = (WIDTH+1)'({r, q[WIDTH-1]});

   sub_ripple #(.N(WIDTH + 1)) u_sub (
      .a     (t),
      .b     ({1'b0, d}),
      .diff  (diff),
      .borrow(borrow)
   );

   assign r_nx   = borrow ? t : diff;
   assign q_nx   = {q[WIDTH-2:0], ~borrow};
   assign accept = (state == ST_IDLE) && start;
   assign last   = (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state and handshake outputs.
   // A zero divisor still passes through RUN for one edge (no iteration) so
   // done lands one cycle after the accept edge's successor.
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (div_by_zero || last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         d           <= '0;
         q           <= '0;
         r           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         d   <= divisor;
         q   <= dividend;
         r   <= '0;
         cnt <= '0;
         if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            div_by_zero <= 1'b0;
         end
      end else if (state == ST_RUN && !div_by_zero) begin
         r   <= r_nx;
         q   <= q_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            quotient  <= q_nx;
            remainder <= r_nx[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_seq_divider5.sv
// Directed and exhaustive checks for seq_divider5 (WIDTH=5).
module tb_seq_divider5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] dividend = '0;
   logic [4:0] divisor = '0;
   logic       ready, done, div_by_zero;
   logic [4:0] quotient, remainder;

   int n_vec  = 0;
   int n_miss = 0;
   int done_cnt = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] q;
      logic [4:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   vec_t tbl[7];

   seq_divider5 #(.WIDTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .ready      (ready),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // done/ready exclusivity and done pulse counting
   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) done_cnt++;
         chk("done_ready_exclusive", {31'd0, done & ready}, 32'd0);
      end
   end

   // Wait for ready, issue one start, report result, latency (edges counting
   // the accept edge as 1) and accept time.
   task automatic run_div(input logic [4:0] a, input logic [4:0] b,
                          output logic [4:0] qo, output logic [4:0] ro,
                          output logic dzo, output int lat, output longint acc);
      int budget;
      budget = 0;
      @(negedge clk);
      while (ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("ready_before_start", {31'd0, ready}, 32'd1);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      acc = $time;
      lat = 1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 5'($urandom);
      divisor  = 5'($urandom);
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      qo  = quotient;
      ro  = remainder;
      dzo = div_by_zero;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] q, r, eq, er;
      logic       dz;
      int         lat, base, budget;
      longint     acc, prev_acc;
      logic [4:0] prev_b;
      bit         first;

      tbl[0] = '{a:5'd27, b:5'd5,  q:5'd5,  r:5'd2,  dz:1'b0, lat:6};
      tbl[1] = '{a:5'd31, b:5'd1,  q:5'd31, r:5'd0,  dz:1'b0, lat:6};
      tbl[2] = '{a:5'd3,  b:5'd7,  q:5'd0,  r:5'd3,  dz:1'b0, lat:6};
      tbl[3] = '{a:5'd0,  b:5'd9,  q:5'd0,  r:5'd0,  dz:1'b0, lat:6};
      tbl[4] = '{a:5'd31, b:5'd31, q:5'd1,  r:5'd0,  dz:1'b0, lat:6};
      tbl[5] = '{a:5'd13, b:5'd0,  q:5'd31, r:5'd13, dz:1'b1, lat:2};
      tbl[6] = '{a:5'd30, b:5'd4,  q:5'd7,  r:5'd2,  dz:1'b0, lat:6};

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_quotient", {27'd0, quotient}, 32'd0);
      chk("reset_remainder", {27'd0, remainder}, 32'd0);
      chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);

      // Directed table
      foreach (tbl[i]) begin
         run_div(tbl[i].a, tbl[i].b, q, r, dz, lat, acc);
         chk($sformatf("tbl%0d_quotient", i), {27'd0, q}, {27'd0, tbl[i].q});
         chk($sformatf("tbl%0d_remainder", i), {27'd0, r}, {27'd0, tbl[i].r});
         chk($sformatf("tbl%0d_dbz", i), {31'd0, dz}, {31'd0, tbl[i].dz});
         chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
         repeat (3) @(negedge clk);
         chk($sformatf("tbl%0d_done_single", i), {31'd0, done}, 32'd0);
         chk($sformatf("tbl%0d_hold_quotient", i), {27'd0, quotient}, {27'd0, tbl[i].q});
         chk($sformatf("tbl%0d_hold_remainder", i), {27'd0, remainder}, {27'd0, tbl[i].r});
      end

      // Busy handling: start during RUN and DONE is ignored
      @(negedge clk);
      base     = done_cnt;
      start    = 1'b1;
      dividend = 5'd20;
      divisor  = 5'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      dividend = 5'd9;
      divisor  = 5'd2;
      @(negedge clk);
      start  = 1'b0;
      budget = 0;
      while (done !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("busy_done_seen", {31'd0, done}, 32'd1);
      chk("busy_quotient", {27'd0, quotient}, 32'd6);
      chk("busy_remainder", {27'd0, remainder}, 32'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ready_after_done", {31'd0, ready}, 32'd1);
      repeat (10) @(negedge clk);
      #1;
      chk("busy_single_done", done_cnt - base, 1);
      chk("busy_hold_quotient", {27'd0, quotient}, 32'd6);

      // Reset on the 3rd RUN edge aborts without done
      start    = 1'b1;
      dividend = 5'd30;
      divisor  = 5'd4;
      @(negedge clk);
      start = 1'b0;
      base  = done_cnt;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_quotient", {27'd0, quotient}, 32'd0);
      chk("midrst_remainder", {27'd0, remainder}, 32'd0);
      chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt - base, 0);
      run_div(5'd30, 5'd4, q, r, dz, lat, acc);
      chk("midrst_redo_quotient", {27'd0, q}, 32'd7);
      chk("midrst_redo_remainder", {27'd0, r}, 32'd2);

      // Simultaneous rst and start: rst wins
      @(negedge clk);
      @(negedge clk);
      base     = done_cnt;
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 5'd10;
      divisor  = 5'd2;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_ready", {31'd0, ready}, 32'd1);
      repeat (8) @(negedge clk);
      #1;
      chk("rst_start_no_done", done_cnt - base, 0);

      // Exhaustive back-to-back sweep against a behavioural model
      first    = 1'b1;
      prev_acc = 0;
      prev_b   = '0;
      for (int unsigned a = 0; a < 32; a++) begin
         for (int unsigned b = 0; b < 32; b++) begin
            run_div(5'(a), 5'(b), q, r, dz, lat, acc);
            if (b == 0) begin
               eq = 5'd31;
               er = 5'(a);
            end else begin
               eq = 5'(a / b);
               er = 5'(a % b);
            end
            chk($sformatf("sweep_%0d_%0d_result", a, b), {21'd0, q, r, dz},
                {21'd0, eq, er, (b == 0) ? 1'b1 : 1'b0});
            if (b != 0)
               chk($sformatf("sweep_%0d_%0d_invariant", a, b),
                   {31'd0, (32'(q) * b + 32'(r) == a) && (32'(r) < b)}, 32'd1);
            if (!first)
               chk($sformatf("sweep_%0d_%0d_interval", a, b), 32'((acc - prev_acc) / 10),
                   (prev_b == 0) ? 32'd3 : 32'd7);
            first    = 1'b0;
            prev_acc = acc;
            prev_b   = 5'(b);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
